counter_control: RTL and testbench
==================================

Name: counter_control

Overview:
- 64-bit free-running timer count (TDR) with programmable prescaler, software load and debug halt.
- Sits directly upstream of the interrupt/compare stage.
- TDR output feeds the compare logic against TCMP.
- Control inputs come from the register block: timer_en, div_en, div_val, and the TDR0/TDR1 write strobes.

Parameters:
- CNT_W, 64: counter width (fixed 64; parameter for lint/readability only).
- DIV_MAX, 8: maximum div_val honoured; larger values clamp to DIV_MAX.

Ports:
- sys_clk  input  1  system clock; all state on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- timer_en  input  1  counting enable (level).
- div_en  input  1  1 = prescaler active; 0 = count every cycle.
- div_val  input  4  prescale exponent; divide by 2^div_val.
- tdr0_wr  input  1  one-cycle strobe; load wdata into TDR[31:0].
- tdr1_wr  input  1  one-cycle strobe; load wdata into TDR[63:32].
- wdata  input  32  write data for TDR loads.
- dbg_mode  input  1  core in debug mode.
- halt_req  input  1  debug halt request (level).
- TDR  output  64  current count value.
- cnt_tick  output  1  one-cycle pulse, high in cycles where TDR increments.
- halt_ack  output  1  halt acknowledged.

Behaviour:
- Reset (async, sys_rst_n=0): TDR=0, prescaler count=0, cnt_tick=0, halt_ack=0, timer_en_d=0, div_cfg_d=0.
- halted (combinational) = halt_req & dbg_mode.
- halt_ack: registered copy of halted; 1-cycle latency in both directions.
- Effective limit L = div_en ? 2^min(div_val, DIV_MAX) : 1. Range is 1..256.
- Prescaler: 8-bit up-counter pcnt, active when timer_en=1 and halted=0.
  - pcnt == L-1: cnt_tick=1 in that cycle, pcnt wraps to 0 on the next edge.
  - Otherwise pcnt increments.
  - With L=1, cnt_tick is high every active cycle.
- cnt_tick is combinational from pcnt, L, timer_en and halted. It is never high while timer_en=0 or halted=1.
- pcnt clears to 0 when:
  - timer_en=0, or
  - any change in {div_en, div_val}, detected against the registered previous value. The first period after a change is a full L cycles.
- halted=1: pcnt and TDR hold; no ticks. Counting resumes from the held state when halted falls.
- TDR update priority per edge, highest first:
  1. tdr0_wr / tdr1_wr: load the addressed half from wdata; the other half holds. If both are set, both halves load from the same wdata. A load overrides any increment in that cycle.
  2. timer_en falling edge (timer_en_d=1, timer_en=0): TDR cleared to 0.
  3. cnt_tick=1: TDR <= TDR + 1, 64-bit modulo; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  4. Otherwise TDR holds.
- Writes are accepted regardless of timer_en and halted.
- TDR output is the register itself. An increment is visible the cycle after cnt_tick.
- Reset mid-count: immediate return to reset values; no tick is generated after reset release until timer_en=1.

Test Plan:
- Reset, then timer_en=1, div_en=0 for 10 cycles -> TDR=10, cnt_tick high all 10 cycles, halt_ack=0.
- div_en=1, div_val=2, timer_en=1 for 16 cycles from TDR=0 -> cnt_tick every 4th cycle, TDR=4.
  - Then div_val=15 -> clamps to 256-cycle period; pcnt restarts at 0.
- tdr0_wr and tdr1_wr with wdata=0xFFFF_FFFF, div_en=0, timer_en=1 -> TDR=0xFFFF_FFFF_FFFF_FFFF; next tick -> TDR=0.
  - Write coincident with tick -> loaded value wins with no +1.
- timer_en 1->0 with TDR=0x1234 -> TDR=0 next edge, cnt_tick=0.
  - tdr0_wr in the same cycle with wdata=0x55 -> TDR=0x55 (write priority).
- dbg_mode=1, halt_req=1 at TDR=7 -> halt_ack=1 one cycle later; TDR stays 7 and pcnt frozen.
  - halt_req=0 -> counting resumes from 7; halt_ack falls one cycle later.
  - halt_req=1 with dbg_mode=0 -> no halt.
- Assert sys_rst_n=0 mid-count with div_val=3, pcnt=5 -> TDR=0, pcnt=0 immediately.
  - After release with timer_en=1, first tick after 8 cycles.

Source files
------------

// File: rtl/counter_control.sv
// -----------------------------------------------------------------------------
// counter_control
//
// 64-bit free-running timer count (TDR) with a power-of-two prescaler,
// software half-word loads and a debug halt. TDR feeds the downstream
// compare stage directly from its register.
//
// Ports:
//   sys_clk    in   system clock, all state on rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   timer_en   in   counting enable (level); its falling edge clears TDR
//   div_en     in   1 = prescaler active, 0 = count every cycle
//   div_val    in   prescale exponent, divide by 2^min(div_val, DIV_MAX)
//   tdr0_wr    in   one-cycle strobe, load wdata into TDR[31:0]
//   tdr1_wr    in   one-cycle strobe, load wdata into TDR[63:32]
//   wdata      in   write data for TDR loads
//   dbg_mode   in   core is in debug mode
//   halt_req   in   debug halt request (level), honoured only in debug mode
//   TDR        out  current count value
//   cnt_tick   out  high in every cycle where TDR increments on the next edge
//   halt_ack   out  registered copy of the effective halt
// -----------------------------------------------------------------------------
module counter_control #(
   parameter int CNT_W   = 64,
   parameter int DIV_MAX = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             timer_en,
   input  logic             div_en,
   input  logic [3:0]       div_val,
   input  logic             tdr0_wr,
   input  logic             tdr1_wr,
   input  logic [31:0]      wdata,
   input  logic             dbg_mode,
   input  logic             halt_req,
   output logic [CNT_W-1:0] TDR,
   output logic             cnt_tick,
   output logic             halt_ack
);

   // The prescaler counts 0..L-1 with L up to 2^DIV_MAX, so DIV_MAX bits
   // hold pcnt and one more bit holds L itself.
   localparam int                PCNT_W    = DIV_MAX;
   localparam int                LIM_W     = DIV_MAX + 1;
   localparam logic [3:0]        DIV_MAX_E = 4'(DIV_MAX);
   localparam logic [LIM_W-1:0]  LIM_ONE   = LIM_W'(1);
   localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [PCNT_W-1:0] pcnt;
   logic              timer_en_d;
   logic [4:0]        div_cfg_d;

   logic              halted;
   logic [3:0]        div_exp;
   logic [LIM_W-1:0]  limit;
   logic              pcnt_last;
   logic              cfg_changed;
   logic              en_fall;

   // NOTE: every signal gets a value on every path through an always_comb,
   // otherwise synthesis infers a latch to hold the missing case.
   always_comb begin
      halted      = halt_req & dbg_mode;
      div_exp     = (div_val > DIV_MAX_E) ? DIV_MAX_E : div_val;
      limit       = div_en ? (LIM_ONE << div_exp) : LIM_ONE;
      // Compare one bit wider so L = 2^DIV_MAX gives a last value of all ones.
      pcnt_last   = ({1'b0, pcnt} == (limit - LIM_ONE));
      cnt_tick    = timer_en & ~halted & pcnt_last;
      cfg_changed = ({div_en, div_val} != div_cfg_d);
      en_fall     = timer_en_d & ~timer_en;
   end

   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         TDR        <= '0;
         pcnt       <= '0;
         timer_en_d <= 1'b0;
         div_cfg_d  <= '0;
         halt_ack   <= 1'b0;
      end else begin
         timer_en_d <= timer_en;
         div_cfg_d  <= {div_en, div_val};
         halt_ack   <= halted;

         // A new divide setting restarts the period so the first tick after
         // a change comes a full L cycles later; a halt merely freezes it.
         if (!timer_en || cfg_changed) begin
            pcnt <= '0;
         end else if (!halted) begin
            pcnt <= pcnt_last ? '0 : pcnt + PCNT_ONE;
         end

         // Software loads beat the enable-fall clear, which beats the tick.
         if (tdr0_wr || tdr1_wr) begin
            if (tdr0_wr) TDR[31:0]       <= wdata;
            if (tdr1_wr) TDR[CNT_W-1:32] <= wdata;
         end else if (en_fall) begin
            TDR <= '0;
         end else if (cnt_tick) begin
            TDR <= TDR + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_counter_control.sv
// -----------------------------------------------------------------------------
// tb_counter_control
//
// Self-checking bench for counter_control. A behavioural model tracks the
// count, the position inside the current prescale period, the previous
// enable and divide setting, and the acknowledged halt. Inputs change on the
// falling clock edge; cnt_tick is sampled just before the rising edge and
// TDR / halt_ack on the following falling edge.
// -----------------------------------------------------------------------------
module tb_counter_control;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        timer_en;
   logic        div_en;
   logic [3:0]  div_val;
   logic        tdr0_wr;
   logic        tdr1_wr;
   logic [31:0] wdata;
   logic        dbg_mode;
   logic        halt_req;
   logic [63:0] TDR;
   logic        cnt_tick;
   logic        halt_ack;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [63:0] m_tdr;
   int          m_phase;
   bit          m_ten_d;
   logic [4:0]  m_cfg_d;
   bit          m_hack;

   int   obs_ticks;
   int   exp_ticks;
   logic last_obs_tick;
   logic last_exp_tick;

   counter_control #(.CNT_W(64), .DIV_MAX(8)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .timer_en  (timer_en),
      .div_en    (div_en),
      .div_val   (div_val),
      .tdr0_wr   (tdr0_wr),
      .tdr1_wr   (tdr1_wr),
      .wdata     (wdata),
      .dbg_mode  (dbg_mode),
      .halt_req  (halt_req),
      .TDR       (TDR),
      .cnt_tick  (cnt_tick),
      .halt_ack  (halt_ack)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, limit 500000", $time);
      $fatal(1, "watchdog expired");
   end

   // Number of cycles per tick for a given setting.
   function automatic int period(bit en, logic [3:0] v);
      int e;
      e = (v > 4'd8) ? 8 : int'(v);
      return en ? (1 << e) : 1;
   endfunction

   task automatic model_reset();
      m_tdr   = '0;
      m_phase = 0;
      m_ten_d = 1'b0;
      m_cfg_d = '0;
      m_hack  = 1'b0;
   endtask

   // Advance one clock: sample cnt_tick before the rising edge, update the
   // model with the inputs seen at that edge, return on the falling edge.
   task automatic step();
      int per;
      bit h;
      bit t;
      #1;
      per = period(div_en, div_val);
      h   = halt_req && dbg_mode;
      t   = timer_en && !h && (m_phase == per - 1);
      last_obs_tick = cnt_tick;
      last_exp_tick = t;
      if (cnt_tick === 1'b1) obs_ticks++;
      if (t) exp_ticks++;
      @(posedge sys_clk);
      if (tdr0_wr || tdr1_wr) begin
         if (tdr0_wr) m_tdr[31:0]  = wdata;
         if (tdr1_wr) m_tdr[63:32] = wdata;
      end else if (m_ten_d && !timer_en) begin
         m_tdr = '0;
      end else if (t) begin
         m_tdr = m_tdr + 64'd1;
      end
      if (!timer_en || ({div_en, div_val} != m_cfg_d)) m_phase = 0;
      else if (!h) m_phase = (m_phase + 1) % per;
      m_ten_d = timer_en;
      m_cfg_d = {div_en, div_val};
      m_hack  = h;
      @(negedge sys_clk);
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      timer_en  = 1'b0;
      div_en    = 1'b0;
      div_val   = 4'd0;
      tdr0_wr   = 1'b0;
      tdr1_wr   = 1'b0;
      wdata     = '0;
      dbg_mode  = 1'b0;
      halt_req  = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++;
      if (TDR !== 64'd0) begin
         failures++;
         $display("FAIL reset_tdr: got %h want 0", TDR);
      end
      checks++;
      if (cnt_tick !== 1'b0) begin
         failures++;
         $display("FAIL reset_tick: got %b want 0", cnt_tick);
      end
      checks++;
      if (halt_ack !== 1'b0) begin
         failures++;
         $display("FAIL reset_halt_ack: got %b want 0", halt_ack);
      end
      model_reset();
      sys_rst_n = 1'b1;
   endtask

   task automatic test_count_basic();
      timer_en  = 1'b1;
      obs_ticks = 0;
      exp_ticks = 0;
      repeat (10) step();
      checks++;
      if (TDR !== 64'd10) begin
         failures++;
         $display("FAIL basic_tdr: got %0d want 10", TDR);
      end
      checks++;
      if (obs_ticks !== 10) begin
         failures++;
         $display("FAIL basic_ticks: got %0d want 10", obs_ticks);
      end
      checks++;
      if (halt_ack !== 1'b0) begin
         failures++;
         $display("FAIL basic_halt_ack: got %b want 0", halt_ack);
      end
   endtask

   task automatic test_prescale();
      logic [15:0] pat;
      // Enable fall clears TDR; the new divide setting is absorbed while idle.
      timer_en = 1'b0;
      div_en   = 1'b1;
      div_val  = 4'd2;
      step();
      timer_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         pat[i] = last_obs_tick;
      end
      checks++;
      if (pat !== 16'h8888) begin
         failures++;
         $display("FAIL prescale_pattern: got %h want 8888", pat);
      end
      checks++;
      if (TDR !== 64'd4) begin
         failures++;
         $display("FAIL prescale_tdr: got %0d want 4", TDR);
      end
   endtask

   task automatic test_clamp();
      int first;
      first   = -1;
      div_val = 4'd15;
      // Step 0 is the cycle carrying the new setting; the 256-cycle period
      // starts after it, so the first tick lands on step 256.
      for (int i = 0; i < 300; i++) begin
         step();
         if (first < 0 && last_obs_tick === 1'b1) first = i;
      end
      checks++;
      if (first !== 256) begin
         failures++;
         $display("FAIL clamp_first_tick: got step %0d want 256", first);
      end
      checks++;
      if (TDR !== 64'd5) begin
         failures++;
         $display("FAIL clamp_tdr: got %0d want 5", TDR);
      end
   endtask

   task automatic test_wrap_write();
      div_en  = 1'b0;
      div_val = 4'd0;
      step();
      tdr0_wr = 1'b1;
      tdr1_wr = 1'b1;
      wdata   = 32'hFFFF_FFFF;
      step();
      checks++;
      if (last_obs_tick !== 1'b1) begin
         failures++;
         $display("FAIL write_tick_coincident: got %b want 1", last_obs_tick);
      end
      checks++;
      if (TDR !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         failures++;
         $display("FAIL write_all_ones: got %h want ffffffffffffffff", TDR);
      end
      tdr0_wr = 1'b0;
      tdr1_wr = 1'b0;
      step();
      checks++;
      if (TDR !== 64'd0) begin
         failures++;
         $display("FAIL wrap_to_zero: got %h want 0", TDR);
      end
      tdr0_wr = 1'b1;
      wdata   = 32'h1234_5678;
      step();
      checks++;
      if (TDR !== 64'h0000_0000_1234_5678) begin
         failures++;
         $display("FAIL write_low_half: got %h want 0000000012345678", TDR);
      end
      tdr0_wr = 1'b0;
      tdr1_wr = 1'b1;
      wdata   = 32'hA5A5_A5A5;
      step();
      tdr1_wr = 1'b0;
      checks++;
      if (TDR !== 64'hA5A5_A5A5_1234_5678) begin
         failures++;
         $display("FAIL write_high_half: got %h want a5a5a5a512345678", TDR);
      end
   endtask

   task automatic test_enable_fall();
      tdr0_wr = 1'b1;
      tdr1_wr = 1'b1;
      wdata   = 32'h0;
      step();
      tdr1_wr = 1'b0;
      wdata   = 32'h1234;
      step();
      tdr0_wr = 1'b0;
      checks++;
      if (TDR !== 64'h1234) begin
         failures++;
         $display("FAIL fall_setup: got %h want 1234", TDR);
      end
      timer_en = 1'b0;
      step();
      checks++;
      if (last_obs_tick !== 1'b0) begin
         failures++;
         $display("FAIL fall_tick: got %b want 0", last_obs_tick);
      end
      checks++;
      if (TDR !== 64'd0) begin
         failures++;
         $display("FAIL fall_clear: got %h want 0", TDR);
      end
      timer_en = 1'b1;
      tdr0_wr  = 1'b1;
      wdata    = 32'h1234;
      step();
      timer_en = 1'b0;
      wdata    = 32'h55;
      step();
      tdr0_wr  = 1'b0;
      checks++;
      if (TDR !== 64'h55) begin
         failures++;
         $display("FAIL fall_write_priority: got %h want 55", TDR);
      end
   endtask

   task automatic test_halt();
      int first;
      timer_en = 1'b1;
      tdr0_wr  = 1'b1;
      wdata    = 32'd7;
      step();
      tdr0_wr  = 1'b0;
      dbg_mode = 1'b1;
      halt_req = 1'b1;
      #1;
      checks++;
      if (halt_ack !== 1'b0) begin
         failures++;
         $display("FAIL halt_ack_latency: got %b want 0 before edge", halt_ack);
      end
      step();
      checks++;
      if (halt_ack !== 1'b1) begin
         failures++;
         $display("FAIL halt_ack_rise: got %b want 1", halt_ack);
      end
      repeat (3) step();
      checks++;
      if (TDR !== 64'd7) begin
         failures++;
         $display("FAIL halt_hold: got %0d want 7", TDR);
      end
      halt_req = 1'b0;
      #1;
      checks++;
      if (halt_ack !== 1'b1 || cnt_tick !== 1'b1) begin
         failures++;
         $display("FAIL halt_release: got ack=%b tick=%b want ack=1 tick=1", halt_ack, cnt_tick);
      end
      step();
      checks++;
      if (TDR !== 64'd8 || halt_ack !== 1'b0) begin
         failures++;
         $display("FAIL halt_resume: got tdr=%0d ack=%b want tdr=8 ack=0", TDR, halt_ack);
      end
      dbg_mode = 1'b0;
      halt_req = 1'b1;
      repeat (3) step();
      checks++;
      if (TDR !== 64'd11 || halt_ack !== 1'b0) begin
         failures++;
         $display("FAIL halt_no_dbg: got tdr=%0d ack=%b want tdr=11 ack=0", TDR, halt_ack);
      end
      // Freeze the prescaler mid-period: two counts in, five cycles halted,
      // then the remaining counts before the tick must still be owed.
      halt_req = 1'b0;
      div_en   = 1'b1;
      div_val  = 4'd2;
      repeat (3) step();
      dbg_mode = 1'b1;
      halt_req = 1'b1;
      repeat (5) step();
      dbg_mode = 1'b0;
      halt_req = 1'b0;
      first    = -1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (first < 0 && last_obs_tick === 1'b1) first = i;
      end
      checks++;
      if (first !== 1) begin
         failures++;
         $display("FAIL halt_pcnt_frozen: got first tick at step %0d want 1", first);
      end
      checks++;
      if (TDR !== m_tdr) begin
         failures++;
         $display("FAIL halt_model: got %h want %h", TDR, m_tdr);
      end
   endtask

   task automatic test_reset_midcount();
      int first;
      bit reached;
      timer_en = 1'b1;
      div_en   = 1'b1;
      div_val  = 4'd3;
      reached  = 1'b0;
      for (int i = 0; i < 40 && !reached; i++) begin
         step();
         if (m_phase == 5) reached = 1'b1;
      end
      checks++;
      if (!reached || TDR !== m_tdr) begin
         failures++;
         $display("FAIL midcount_setup: got reached=%b tdr=%h want reached=1 tdr=%h", reached, TDR, m_tdr);
      end
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (TDR !== 64'd0 || cnt_tick !== 1'b0 || halt_ack !== 1'b0) begin
         failures++;
         $display("FAIL midcount_reset: got tdr=%h tick=%b ack=%b want 0 0 0", TDR, cnt_tick, halt_ack);
      end
      model_reset();
      sys_rst_n = 1'b1;
      // The first edge after release sees the divide setting differ from its
      // reset value and restarts the period, then eight counts follow.
      first = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (first < 0 && last_obs_tick === 1'b1) first = i;
      end
      checks++;
      if (first !== 9) begin
         failures++;
         $display("FAIL midcount_first_tick: got cycle %0d want 9", first);
      end
      checks++;
      if (TDR !== m_tdr) begin
         failures++;
         $display("FAIL midcount_model: got %h want %h", TDR, m_tdr);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         timer_en = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 29) == 0) begin
            div_en  = 1'($urandom_range(0, 1));
            div_val = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
         if ($urandom_range(0, 9) == 0) dbg_mode = ~dbg_mode;
         tdr0_wr = ($urandom_range(0, 19) == 0);
         tdr1_wr = ($urandom_range(0, 19) == 0);
         wdata   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         step();
         checks++;
         if (TDR !== m_tdr || halt_ack !== m_hack || last_obs_tick !== last_exp_tick) begin
            failures++;
            bad++;
            if (bad <= 10)
               $display("FAIL random_step %0d: got tdr=%h ack=%b tick=%b want tdr=%h ack=%b tick=%b",
                        i, TDR, halt_ack, last_obs_tick, m_tdr, m_hack, last_exp_tick);
         end
      end
      tdr0_wr  = 1'b0;
      tdr1_wr  = 1'b0;
      halt_req = 1'b0;
      dbg_mode = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_basic();
      test_prescale();
      test_clamp();
      test_wrap_write();
      test_enable_fall();
      test_halt();
      test_reset_midcount();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
